// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings and default opcodes.
// Used by the TAP controller and the scan datapath.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'b0000,
        RUN_TEST_IDLE    = 4'b0001,
        SELECT_DR        = 4'b0010,
        CAPTURE_DR       = 4'b0011,
        SHIFT_DR         = 4'b0100,
        EXIT1_DR         = 4'b0101,
        PAUSE_DR         = 4'b0110,
        EXIT2_DR         = 4'b0111,
        UPDATE_DR        = 4'b1000,
        SELECT_IR        = 4'b1001,
        CAPTURE_IR       = 4'b1010,
        SHIFT_IR         = 4'b1011,
        EXIT1_IR         = 4'b1100,
        PAUSE_IR         = 4'b1101,
        EXIT2_IR         = 4'b1110,
        UPDATE_IR        = 4'b1111
    } tap_state_e;

    localparam logic [3:0]  INSTR_IDCODE_DEF = 4'b0001;
    localparam logic [3:0]  INSTR_USER_DEF   = 4'b0010;
    localparam logic [3:0]  INSTR_BYPASS_DEF = 4'b1111;
    localparam logic [31:0] IDCODE_DEF       = 32'h1234_5ABD;

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic capture/shift/hold register, shifting right with the
// serial input entering the MSB; the LSB is the serial output.
module jtag_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cap_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] cap_val_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shifted;

    generate
        if (WIDTH == 1) begin : g_one
            assign shifted = sin_i;
        end else begin : g_wide
            assign shifted = {sin_i, q_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (cap_i) begin
            q_d = cap_val_i;
        end else if (shift_i) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jtag_scan_datapath.sv
// JTAG scan datapath: IR, BYPASS, IDCODE and USER data registers,
// update shadows and the negedge-registered TDO path.
module jtag_scan_datapath
    import jtag_pkg::*;
#(
    parameter int                     IR_WIDTH     = 4,
    parameter int                     USER_WIDTH   = 8,
    parameter logic [31:0]            IDCODE_VAL   = IDCODE_DEF,
    parameter logic [IR_WIDTH-1:0]    INSTR_IDCODE = IR_WIDTH'(INSTR_IDCODE_DEF),
    parameter logic [IR_WIDTH-1:0]    INSTR_USER   = IR_WIDTH'(INSTR_USER_DEF)
) (
    input  logic                  TCLK,
    input  logic                  TRST_N,
    input  logic [3:0]            STATE,
    input  logic                  TDI,
    output logic                  TDO,
    output logic                  TDO_EN,
    output logic [IR_WIDTH-1:0]   IR_Q,
    output logic [USER_WIDTH-1:0] USER_Q,
    output logic                  USER_UPD
);

    localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(2'b01);

    tap_state_e st;
    logic tlr, cap_ir, sh_ir, upd_ir;
    logic cap_dr, sh_dr, upd_dr;
    logic sel_id, sel_user, sel_byp;

    logic [IR_WIDTH-1:0]   ir_shift;
    logic [31:0]           id_shift;
    logic [USER_WIDTH-1:0] user_shift;
    logic                  unused_id;

    logic [IR_WIDTH-1:0]   ir_q_q, ir_q_d;
    logic [USER_WIDTH-1:0] user_q_q, user_q_d;
    logic                  byp_q, byp_d;
    logic                  upd_q, upd_d;
    logic                  ser;
    logic                  tdo_q, tdo_en_q;

    assign st     = tap_state_e'(STATE);
    assign tlr    = (st == TEST_LOGIC_RESET);
    assign cap_ir = (st == CAPTURE_IR);
    assign sh_ir  = (st == SHIFT_IR);
    assign upd_ir = (st == UPDATE_IR);
    assign cap_dr = (st == CAPTURE_DR);
    assign sh_dr  = (st == SHIFT_DR);
    assign upd_dr = (st == UPDATE_DR);

    // IR_Q only moves in update_IR or TLR, so it is stable for a whole DR scan.
    assign sel_id   = (ir_q_q == INSTR_IDCODE);
    assign sel_user = (ir_q_q == INSTR_USER) && !sel_id;
    assign sel_byp  = !sel_id && !sel_user;

    jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir (
        .clk_i     (TCLK),
        .rst_ni    (TRST_N),
        .cap_i     (cap_ir),
        .shift_i   (sh_ir),
        .cap_val_i (IR_CAP),
        .sin_i     (TDI),
        .q_o       (ir_shift)
    );

    jtag_shift_reg #(.WIDTH(32)) u_id (
        .clk_i     (TCLK),
        .rst_ni    (TRST_N),
        .cap_i     (cap_dr && sel_id),
        .shift_i   (sh_dr && sel_id),
        .cap_val_i (IDCODE_VAL),
        .sin_i     (TDI),
        .q_o       (id_shift)
    );

    jtag_shift_reg #(.WIDTH(USER_WIDTH)) u_user (
        .clk_i     (TCLK),
        .rst_ni    (TRST_N),
        .cap_i     (cap_dr && sel_user),
        .shift_i   (sh_dr && sel_user),
        .cap_val_i (user_q_q),
        .sin_i     (TDI),
        .q_o       (user_shift)
    );

    assign unused_id = ^id_shift[31:1];

    always_comb begin
        ir_q_d   = ir_q_q;
        user_q_d = user_q_q;
        byp_d    = byp_q;
        upd_d    = upd_dr && sel_user;
        if (tlr) begin
            ir_q_d = INSTR_IDCODE;
        end else if (upd_ir) begin
            ir_q_d = ir_shift;
        end
        if (upd_dr && sel_user) begin
            user_q_d = user_shift;
        end
        if (cap_dr && sel_byp) begin
            byp_d = 1'b0;
        end else if (sh_dr && sel_byp) begin
            byp_d = TDI;
        end
    end

    always_ff @(posedge TCLK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_q_q   <= INSTR_IDCODE;
            user_q_q <= '0;
            byp_q    <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            ir_q_q   <= ir_q_d;
            user_q_q <= user_q_d;
            byp_q    <= byp_d;
            upd_q    <= upd_d;
        end
    end

    always_comb begin
        ser = 1'b0;
        if (sh_ir) begin
            ser = ir_shift[0];
        end else if (sh_dr) begin
            if (sel_id) begin
                ser = id_shift[0];
            end else if (sel_user) begin
                ser = user_shift[0];
            end else begin
                ser = byp_q;
            end
        end
    end

    // TDO launches on the falling edge so the receiver samples it mid-cycle.
    always_ff @(negedge TCLK or negedge TRST_N) begin
        if (!TRST_N) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= ser;
            tdo_en_q <= sh_ir || sh_dr;
        end
    end

    assign TDO      = tdo_q;
    assign TDO_EN   = tdo_en_q;
    assign IR_Q     = ir_q_q;
    assign USER_Q   = user_q_q;
    assign USER_UPD = upd_q;

endmodule

// File: tb/tb_jtag_scan_datapath.sv
// Directed bench for jtag_scan_datapath with a TDO scoreboard queue.
// STATE is driven just after each posedge, as a TAP controller would.
module tb_jtag_scan_datapath;
    import jtag_pkg::*;

    logic       TCLK = 1'b0;
    logic       TRST_N = 1'b1;
    logic [3:0] STATE = TEST_LOGIC_RESET;
    logic       TDI = 1'b0;
    logic       TDO, TDO_EN, USER_UPD;
    logic [3:0] IR_Q;
    logic [7:0] USER_Q;

    int    checks = 0;
    int    failures = 0;
    int    upd_cnt = 0;
    bit    exp_q[$];
    string phase = "init";

    always #5 TCLK = ~TCLK;

    jtag_scan_datapath dut (
        .TCLK     (TCLK),
        .TRST_N   (TRST_N),
        .STATE    (STATE),
        .TDI      (TDI),
        .TDO      (TDO),
        .TDO_EN   (TDO_EN),
        .IR_Q     (IR_Q),
        .USER_Q   (USER_Q),
        .USER_UPD (USER_UPD)
    );

    always @(negedge TCLK) if (USER_UPD === 1'b1) upd_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One TCLK cycle in state s; TDO is scored after the falling edge.
    task automatic go(input logic [3:0] s, input logic t);
        bit e;
        STATE = s;
        TDI = t;
        @(negedge TCLK);
        #1;
        if ((s == SHIFT_IR || s == SHIFT_DR) && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({phase, "_tdo"}, 32'(TDO), 32'(e));
            chk({phase, "_tdo_en"}, 32'(TDO_EN), 32'd1);
        end
        @(posedge TCLK);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] v);
        logic [3:0] cap;
        cap = 4'b0001;
        phase = "ir_out";
        go(SELECT_DR, 1'b0);
        go(SELECT_IR, 1'b0);
        go(CAPTURE_IR, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(cap[i]);
        for (int i = 0; i < 4; i++) go(SHIFT_IR, v[i]);
        go(EXIT1_IR, 1'b0);
        go(UPDATE_IR, 1'b0);
        chk("ir_q", 32'(IR_Q), 32'(v));
        go(RUN_TEST_IDLE, 1'b0);
    endtask

    task automatic user_scan(input logic [7:0] din, input logic [7:0] cur);
        int u;
        phase = "user";
        go(SELECT_DR, 1'b0);
        go(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(cur[i]);
        for (int i = 0; i < 8; i++) go(SHIFT_DR, din[i]);
        go(EXIT1_DR, 1'b0);
        u = upd_cnt;
        go(UPDATE_DR, 1'b0);
        chk("user_q", 32'(USER_Q), 32'(din));
        chk("user_upd_hi", 32'(USER_UPD), 32'd1);
        go(RUN_TEST_IDLE, 1'b0);
        chk("user_upd_lo", 32'(USER_UPD), 32'd0);
        chk("user_upd_cnt", 32'(upd_cnt - u), 32'd1);
        chk("user_drain", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [3:0] next_tms1(input logic [3:0] s);
        case (s)
            RUN_TEST_IDLE: return SELECT_DR;
            SELECT_DR:     return SELECT_IR;
            CAPTURE_DR,
            SHIFT_DR:      return EXIT1_DR;
            EXIT1_DR,
            EXIT2_DR:      return UPDATE_DR;
            PAUSE_DR:      return EXIT2_DR;
            UPDATE_DR,
            UPDATE_IR:     return SELECT_DR;
            CAPTURE_IR,
            SHIFT_IR:      return EXIT1_IR;
            EXIT1_IR,
            EXIT2_IR:      return UPDATE_IR;
            PAUSE_IR:      return EXIT2_IR;
            default:       return TEST_LOGIC_RESET;
        endcase
    endfunction

    initial begin
        logic [31:0] idc;
        logic [3:0]  pat;
        logic [3:0]  cur;
        logic        prev;
        int          u;

        idc = 32'h1234_5ABD;

        // Power-on reset asserted between edges.
        #2 TRST_N = 1'b0;
        #1;
        chk("rst_ir_q", 32'(IR_Q), 32'h1);
        chk("rst_user_q", 32'(USER_Q), 32'h0);
        chk("rst_tdo", 32'(TDO), 32'h0);
        chk("rst_tdo_en", 32'(TDO_EN), 32'h0);
        chk("rst_user_upd", 32'(USER_UPD), 32'h0);
        @(posedge TCLK);
        @(posedge TCLK);
        #1 TRST_N = 1'b1;

        // IDCODE read straight after reset.
        go(RUN_TEST_IDLE, 1'b0);
        go(SELECT_DR, 1'b0);
        go(CAPTURE_DR, 1'b0);
        phase = "idcode";
        for (int i = 0; i < 32; i++) exp_q.push_back(idc[i]);
        for (int i = 0; i < 32; i++) go(SHIFT_DR, 1'b0);
        go(EXIT1_DR, 1'b0);
        u = upd_cnt;
        go(UPDATE_DR, 1'b0);
        go(RUN_TEST_IDLE, 1'b0);
        chk("idcode_no_upd", 32'(upd_cnt - u), 32'd0);
        chk("idcode_drain", 32'(exp_q.size()), 32'd0);

        // Select USER, write A5, read it back, then leave 3C behind.
        load_ir(INSTR_USER_DEF);
        user_scan(8'hA5, 8'h00);
        user_scan(8'h00, 8'hA5);
        user_scan(8'h3C, 8'h00);

        // BYPASS: one-cycle delay, first bit out is the captured 0.
        load_ir(INSTR_BYPASS_DEF);
        phase = "bypass";
        pat = 4'b1101;
        go(SELECT_DR, 1'b0);
        go(CAPTURE_DR, 1'b0);
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(prev);
            prev = pat[i];
        end
        for (int i = 0; i < 4; i++) go(SHIFT_DR, pat[i]);
        go(EXIT1_DR, 1'b0);
        u = upd_cnt;
        go(UPDATE_DR, 1'b0);
        go(RUN_TEST_IDLE, 1'b0);
        chk("bypass_no_upd", 32'(upd_cnt - u), 32'd0);
        chk("bypass_user_q", 32'(USER_Q), 32'h3C);
        chk("bypass_drain", 32'(exp_q.size()), 32'd0);

        // TMS held high for five clocks reaches TLR.
        cur = RUN_TEST_IDLE;
        for (int i = 0; i < 5; i++) begin
            cur = next_tms1(cur);
            go(cur, 1'b0);
        end
        chk("tlr_ir_q", 32'(IR_Q), 32'h1);
        chk("tlr_user_q", 32'(USER_Q), 32'h3C);
        go(RUN_TEST_IDLE, 1'b0);

        // Abort a USER shift after three bits.
        load_ir(INSTR_USER_DEF);
        phase = "abort";
        go(SELECT_DR, 1'b0);
        go(CAPTURE_DR, 1'b0);
        for (int i = 0; i < 3; i++) exp_q.push_back(idc[0] & 1'b0);
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(cur[0] & 1'b0);
        exp_q.delete();
        pat = 4'b1100;
        for (int i = 0; i < 3; i++) exp_q.push_back(pat[i]);
        for (int i = 0; i < 3; i++) go(SHIFT_DR, 1'b1);
        u = upd_cnt;
        STATE = SHIFT_DR;
        #2 TRST_N = 1'b0;
        #1;
        chk("abort_user_q", 32'(USER_Q), 32'h0);
        chk("abort_ir_q", 32'(IR_Q), 32'h1);
        chk("abort_tdo", 32'(TDO), 32'h0);
        chk("abort_tdo_en", 32'(TDO_EN), 32'h0);
        chk("abort_user_upd", 32'(USER_UPD), 32'h0);
        @(posedge TCLK);
        #1 TRST_N = 1'b1;
        go(TEST_LOGIC_RESET, 1'b0);
        go(RUN_TEST_IDLE, 1'b0);
        go(RUN_TEST_IDLE, 1'b0);
        chk("abort_no_upd", 32'(upd_cnt - u), 32'd0);
        chk("abort_tdo_en_idle", 32'(TDO_EN), 32'h0);
        chk("abort_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
